// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter.
package imem_pkg;
  localparam int IMEM_WORD_W = 32;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } imem_req_t;

  typedef struct packed {
    logic                   valid;
    logic [IMEM_WORD_W-1:0] data;
    logic                   err;
  } imem_resp_t;

  // Word-aligned and inside the memory.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (64'(addr) < (64'(depth) * 64'd4));
  endfunction
endpackage

// File: rtl/imem_port_arbiter_if.sv
// One requester port of the arbiter: request handshake plus response slot.
interface imem_port_if;
  import imem_pkg::*;
  logic                   req_valid;
  logic [31:0]            req_addr;
  logic                   req_ready;
  logic                   resp_valid;
  logic [IMEM_WORD_W-1:0] resp_data;
  logic                   resp_err;
  logic                   resp_ready;

  modport master (output req_valid, req_addr, resp_ready,
                  input  req_ready, resp_valid, resp_data, resp_err);
  modport slave  (input  req_valid, req_addr, resp_ready,
                  output req_ready, resp_valid, resp_data, resp_err);
endinterface

// File: rtl/imem_resp_slot.sv
// One-entry response register; a load in the same cycle as a drain wins.
module imem_resp_slot
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   load_err,
  input  logic [IMEM_WORD_W-1:0] load_data,
  input  logic                   ready,
  output imem_resp_t             resp,
  output logic                   free
);
  assign free = !resp.valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp <= '0;
    end else if (load) begin
      resp.valid <= 1'b1;
      resp.err   <= load_err;
      resp.data  <= load_err ? '0 : load_data;
    end else if (ready) begin
      resp.valid <= 1'b0;
    end
  end
endmodule

// File: rtl/imem_port_arbiter.sv
// Two-port arbiter for the imem read port: fetch priority with a debug starvation guard.
// Optional grant/error counters enabled by IMEM_ARB_STATS_EN.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int MAX_STREAK = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  imem_port_if.slave             f,
  imem_port_if.slave             d,
  output logic [31:0]            imem_addr,
  input  logic [IMEM_WORD_W-1:0] imem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]            stat_f_grants,
  output logic [31:0]            stat_d_grants,
  output logic [15:0]            stat_err_cnt
`endif
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  imem_req_t   req [2];
  imem_resp_t  rsp [2];
  logic [1:0]  free, elig, gnt, rdy;
  logic [SW-1:0] streak;
  logic [31:0] addr_sel, last_addr;
  logic        bad;

  assign req[0] = '{valid: f.req_valid, addr: f.req_addr};
  assign req[1] = '{valid: d.req_valid, addr: d.req_addr};
  assign rdy    = {d.resp_ready, f.resp_ready};

  // Gating with rst_n keeps every grant off while reset is held.
  assign elig[0] = req[0].valid && free[0] && rst_n;
  assign elig[1] = req[1].valid && free[1] && rst_n;
  assign gnt[1]  = elig[1] && ((streak == STREAK_MAX) || !elig[0]);
  assign gnt[0]  = elig[0] && !gnt[1];

  assign addr_sel  = gnt[1] ? req[1].addr : req[0].addr;
  assign imem_addr = (|gnt) ? addr_sel : last_addr;
  assign bad       = !addr_ok(addr_sel, DEPTH);

  for (genvar g = 0; g < 2; g++) begin : g_slot
    imem_resp_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (gnt[g]),
      .load_err  (bad),
      .load_data (imem_rdata),
      .ready     (rdy[g]),
      .resp      (rsp[g]),
      .free      (free[g])
    );
  end

  assign f.req_ready  = gnt[0];
  assign f.resp_valid = rsp[0].valid;
  assign f.resp_data  = rsp[0].data;
  assign f.resp_err   = rsp[0].err;
  assign d.req_ready  = gnt[1];
  assign d.resp_valid = rsp[1].valid;
  assign d.resp_data  = rsp[1].data;
  assign d.resp_err   = rsp[1].err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr <= '0;
      streak    <= '0;
    end else begin
      if (|gnt) last_addr <= addr_sel;
      // Streak only counts fetch wins while debug is actually waiting.
      if (!req[1].valid || gnt[1])
        streak <= '0;
      else if (gnt[0] && streak != STREAK_MAX)
        streak <= streak + SW'(1);
    end
  end

`ifdef IMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_f_grants <= '0;
      stat_d_grants <= '0;
      stat_err_cnt  <= '0;
    end else begin
      if (gnt[0]) stat_f_grants <= stat_f_grants + 32'd1;
      if (gnt[1]) stat_d_grants <= stat_d_grants + 32'd1;
      if ((|gnt) && bad && stat_err_cnt != 16'hFFFF)
        stat_err_cnt <= stat_err_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized self-checking bench for imem_port_arbiter with a cycle-level reference model.
module tb_imem_port_arbiter;
  localparam int DEPTH = 1024;
  localparam int MAXS  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_port_if fp ();
  imem_port_if dp ();
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] mem [DEPTH];
`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stat_f_grants, stat_d_grants;
  logic [15:0] stat_err_cnt;
`endif

  assign imem_rdata = (imem_addr < 32'(DEPTH * 4)) ? mem[imem_addr[11:2]] : 32'hBAD0_BAD0;

  imem_port_arbiter #(.DEPTH(DEPTH), .MAX_STREAK(MAXS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .f          (fp),
    .d          (dp),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata)
`ifdef IMEM_ARB_STATS_EN
    ,
    .stat_f_grants (stat_f_grants),
    .stat_d_grants (stat_d_grants),
    .stat_err_cnt  (stat_err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference state: contents of each response slot, starvation streak, counters.
  logic        m_fv, m_fe, m_dv, m_de;
  logic [31:0] m_fd, m_dd, m_last;
  int          m_streak, m_fg, m_dg, m_ec;
  logic [1:0]  exp_g, act_g;
  logic [31:0] exp_addr, act_addr;
  logic [67:0] exp_rsp, act_rsp;

  function automatic logic ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < DEPTH * 4);
  endfunction

  task automatic model_reset();
    m_fv = 0; m_fe = 0; m_fd = 0; m_dv = 0; m_de = 0; m_dd = 0;
    m_last = 0; m_streak = 0; m_fg = 0; m_dg = 0; m_ec = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, sample grant before the edge, sample slots after.
  task automatic cyc(input logic fv, input logic [31:0] fa, input logic fr,
                     input logic dv, input logic [31:0] da, input logic dr);
    logic fe, de;
    @(negedge clk);
    fp.req_valid = fv; fp.req_addr = fa; fp.resp_ready = fr;
    dp.req_valid = dv; dp.req_addr = da; dp.resp_ready = dr;
    #1;
    fe = fv && (!m_fv || fr);
    de = dv && (!m_dv || dr);
    if (de && (m_streak == MAXS || !fe)) exp_g = 2'b10;
    else if (fe)                          exp_g = 2'b01;
    else                                  exp_g = 2'b00;
    exp_addr = exp_g[1] ? da : exp_g[0] ? fa : m_last;
    act_g    = {dp.req_ready, fp.req_ready};
    act_addr = imem_addr;
    @(posedge clk);
    if (exp_g[0]) begin
      m_fv = 1; m_fe = !ok(fa); m_fd = m_fe ? 32'd0 : mem[fa[11:2]];
      m_fg++; if (m_fe) m_ec++;
    end else if (fr) m_fv = 0;
    if (exp_g[1]) begin
      m_dv = 1; m_de = !ok(da); m_dd = m_de ? 32'd0 : mem[da[11:2]];
      m_dg++; if (m_de) m_ec++;
    end else if (dr) m_dv = 0;
    if (!dv || exp_g[1]) m_streak = 0;
    else if (exp_g[0] && m_streak < MAXS) m_streak++;
    if (exp_g != 2'b00) m_last = exp_addr;
    #1;
    exp_rsp = {m_fv, m_fe, m_fd, m_dv, m_de, m_dd};
    act_rsp = {fp.resp_valid, fp.resp_err, fp.resp_data, dp.resp_valid, dp.resp_err, dp.resp_data};
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fp.req_valid = 1; fp.req_addr = 32'h4; dp.req_valid = 1; dp.req_addr = 32'h8;
    #1;
    checks++;
    if ({fp.req_ready, dp.req_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b want 00", {fp.req_ready, dp.req_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({fp.resp_valid, fp.resp_err, fp.resp_data, dp.resp_valid, dp.resp_err, dp.resp_data} !== 68'd0) begin
      errors++; $display("FAIL reset_resp got f=%b/%b/%h d=%b/%b/%h want all 0",
        fp.resp_valid, fp.resp_err, fp.resp_data, dp.resp_valid, dp.resp_err, dp.resp_data);
    end
    checks++;
    if (imem_addr !== 32'd0) begin
      errors++; $display("FAIL reset_addr got %h want 0", imem_addr);
    end
    model_reset();
    @(negedge clk);
    fp.req_valid = 0; dp.req_valid = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_stream();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'(i * 4), 1, 0, 0, 1);
      checks++;
      if (act_g !== 2'b01 || act_addr !== 32'(i * 4)) begin
        errors++; $display("FAIL fetch_grant[%0d] got g=%b addr=%h want 01/%h", i, act_g, act_addr, i * 4);
      end
      checks++;
      if (fp.resp_valid !== 1'b1 || fp.resp_err !== 1'b0 || fp.resp_data !== mem[i]) begin
        errors++; $display("FAIL fetch_resp[%0d] got v=%b e=%b d=%h want 1/0/%h",
          i, fp.resp_valid, fp.resp_err, fp.resp_data, mem[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    logic        errs  [3];
    logic [31:0] datas [3];
    addrs = '{32'h2, 32'h1000, 32'h10};
    errs  = '{1'b1, 1'b1, 1'b0};
    datas = '{32'd0, 32'd0, mem[4]};
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, addrs[i], 1);
      checks++;
      if (act_g !== 2'b10 || dp.resp_valid !== 1'b1 || dp.resp_err !== errs[i] || dp.resp_data !== datas[i]) begin
        errors++; $display("FAIL err_case[%0d] got g=%b v=%b e=%b d=%h want 10/1/%b/%h",
          i, act_g, dp.resp_valid, dp.resp_err, dp.resp_data, errs[i], datas[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    cyc(0, 0, 1, 0, 0, 1);
    cyc(1, 32'h40, 0, 0, 0, 1);
    checks++;
    if (fp.resp_valid !== 1'b1 || fp.resp_data !== mem[16]) begin
      errors++; $display("FAIL bp_first got v=%b d=%h want 1/%h", fp.resp_valid, fp.resp_data, mem[16]);
    end
    cyc(1, 32'h44, 0, 1, 32'h48, 1);
    checks++;
    if (act_g !== 2'b10 || fp.resp_data !== mem[16] || dp.resp_data !== mem[18]) begin
      errors++; $display("FAIL bp_held got g=%b fd=%h dd=%h want 10/%h/%h",
        act_g, fp.resp_data, dp.resp_data, mem[16], mem[18]);
    end
    cyc(1, 32'h44, 1, 0, 0, 1);
    checks++;
    if (act_g !== 2'b01 || fp.resp_valid !== 1'b1 || fp.resp_data !== mem[17]) begin
      errors++; $display("FAIL bp_refill got g=%b v=%b d=%h want 01/1/%h",
        act_g, fp.resp_valid, fp.resp_data, mem[17]);
    end
    checks++;
    if (act_rsp !== exp_rsp) begin
      errors++; $display("FAIL bp_model got %h want %h", act_rsp, exp_rsp);
    end
  endtask

  // Both ports saturated: every fifth grant must go to debug.
  task automatic test_starvation(input bool_reset);
    logic [1:0] pat [5];
    pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    if (bool_reset) do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 32'($urandom_range(0, DEPTH - 1)) << 2, 1, 1, 32'($urandom_range(0, DEPTH - 1)) << 2, 1);
      checks++;
      if (act_g !== pat[i % 5]) begin
        errors++; $display("FAIL starve_grant[%0d] got %b want %b", i, act_g, pat[i % 5]);
      end
      checks++;
      if (dp.resp_valid !== (i % 5 == 4)) begin
        errors++; $display("FAIL starve_dvalid[%0d] got %b want %b", i, dp.resp_valid, (i % 5 == 4));
      end
    end
`ifdef IMEM_ARB_STATS_EN
    if (bool_reset) begin
      checks++;
      if (stat_f_grants !== 32'd8 || stat_d_grants !== 32'd2 || stat_err_cnt !== 16'd0) begin
        errors++; $display("FAIL stats_starve got f=%0d d=%0d e=%0d want 8/2/0",
          stat_f_grants, stat_d_grants, stat_err_cnt);
      end
    end
`endif
  endtask

  task automatic test_async_reset();
    cyc(1, 32'h24, 0, 1, 32'h20, 0);
    cyc(1, 32'h28, 0, 1, 32'h20, 0);
    checks++;
    if (fp.resp_valid !== 1'b1 || dp.resp_valid !== 1'b1) begin
      errors++; $display("FAIL ar_setup got f=%b d=%b want 1/1", fp.resp_valid, dp.resp_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fp.resp_valid, dp.resp_valid, fp.req_ready, dp.req_ready} !== 4'b0000) begin
      errors++; $display("FAIL ar_drop got %b want 0000",
        {fp.resp_valid, dp.resp_valid, fp.req_ready, dp.req_ready});
    end
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (fp.resp_valid !== 1'b0 || dp.resp_valid !== 1'b0) begin
      errors++; $display("FAIL ar_hold got f=%b d=%b want 0/0", fp.resp_valid, dp.resp_valid);
    end
    rst_n = 1'b1;
    cyc(1, 32'h30, 1, 0, 0, 1);
    checks++;
    if (act_g !== 2'b01 || fp.resp_valid !== 1'b1 || fp.resp_data !== mem[12]) begin
      errors++; $display("FAIL ar_first got g=%b v=%b d=%h want 01/1/%h",
        act_g, fp.resp_valid, fp.resp_data, mem[12]);
    end
    cyc(0, 0, 1, 0, 0, 1);
    test_starvation(1'b0);
  endtask

  task automatic test_random();
    logic [31:0] fa, da;
    for (int i = 0; i < 400; i++) begin
      fa = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1)) << 2;
      da = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1)) << 2;
      cyc(1'($urandom_range(0, 3) != 0), fa, 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 1)), da, 1'($urandom_range(0, 2) != 0));
      checks++;
      if (act_g !== exp_g || act_addr !== exp_addr) begin
        errors++; $display("FAIL rand_grant[%0d] got g=%b a=%h want %b/%h", i, act_g, act_addr, exp_g, exp_addr);
      end
      checks++;
      if (act_rsp !== exp_rsp) begin
        errors++; $display("FAIL rand_resp[%0d] got %h want %h", i, act_rsp, exp_rsp);
      end
    end
`ifdef IMEM_ARB_STATS_EN
    checks++;
    if (stat_f_grants !== 32'(m_fg) || stat_d_grants !== 32'(m_dg) || stat_err_cnt !== 16'(m_ec)) begin
      errors++; $display("FAIL rand_stats got f=%0d d=%0d e=%0d want %0d/%0d/%0d",
        stat_f_grants, stat_d_grants, stat_err_cnt, m_fg, m_dg, m_ec);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    fp.req_valid = 0; fp.req_addr = 0; fp.resp_ready = 0;
    dp.req_valid = 0; dp.req_addr = 0; dp.resp_ready = 0;
    model_reset();
    test_reset();
    test_fetch_stream();
    test_errors();
    test_backpressure();
    test_starvation(1'b1);
    test_async_reset();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single combinational read port of the instruction memory between two requesters: port 0 (core fetch) and port 1 (debug/readback).
- Each cycle it grants at most one request, drives `imem_addr`, and registers the returned word into a per-port response slot.
- Fetch has priority. A streak counter prevents starvation of the debug port.
- Sits between the fetch stage and the instruction memory.

Parameters:
- DEPTH, 1024: instruction memory depth in 32-bit words. Must be a power of 2. Valid byte addresses are 0 .. DEPTH*4-1.
- MAX_STREAK, 4: maximum consecutive fetch grants while debug is pending.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- f_req_valid  in  1  fetch request valid
- f_req_addr  in  32  fetch byte address
- f_req_ready  out  1  fetch request accepted this cycle
- f_resp_valid  out  1  fetch response slot holds data
- f_resp_data  out  32  fetch response word
- f_resp_err  out  1  fetch response is an error
- f_resp_ready  in  1  fetch consumer takes response
- d_req_valid, d_req_addr, d_req_ready, d_resp_valid, d_resp_data, d_resp_err, d_resp_ready: same as the f_ signals, for the debug port
- imem_addr  out  32  address to instruction memory
- imem_rdata  in  32  combinational read data from instruction memory

Behaviour:
- **Reset:** the whole block uses one clock (clk) and an asynchronous, active-low reset (rst_n). Reset values:
  - both resp_valid = 0
  - resp_data = 0, resp_err = 0
  - streak = 0
  - imem_addr = 0
  - all req_ready = 0
- **Slot free:** a port's slot is free when resp_valid = 0, or when resp_valid = 1 and resp_ready = 1 in the same cycle (drain-and-refill).
- **Eligibility:** a port is eligible when req_valid = 1 and its slot is free.
- **Grant, combinational:**
  - If streak == MAX_STREAK and debug is eligible, grant debug.
  - Otherwise grant fetch if fetch is eligible, else grant debug if debug is eligible.
  - At most one req_ready is high per cycle. req_ready is asserted only for the granted port.
- **Address mux:** imem_addr = granted port's address; it holds its last value when there is no grant.
- **Response latency:** a request accepted in cycle N has its response visible (resp_valid = 1) in cycle N+1.
  - resp_data = imem_rdata sampled at the N clock edge.
  - The slot holds until resp_ready = 1.
- **Error checks:**
  - addr[1:0] != 0, or addr >= DEPTH*4 → resp_err = 1 and resp_data = 0.
  - The request is still accepted and consumes a slot.
- **Streak counter:**
  - Increments on a fetch grant while debug has req_valid = 1, saturating at MAX_STREAK.
  - Clears on any debug grant, or on any cycle where d_req_valid = 0.
- **Simultaneous drain and refill:** the new data wins; resp_valid stays 1.
- **Reset mid-operation:** pending responses are discarded and no grant is issued until rst_n deasserts. Requesters must re-issue.
- **Ordering:** responses are in order per port; no ordering holds across ports.
- **Throughput:** one request per cycle total.

Optional Feature:
- Macro: IMEM_ARB_STATS_EN.
- When defined, add three outputs:
  - stat_f_grants [31:0] and stat_d_grants [31:0]: wrapping grant counters.
  - stat_err_cnt [15:0]: counts error responses, saturating at 16'hFFFF.
- All three reset to 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package imem_pkg:
  - IMEM_WORD_W = 32
  - typedef imem_req_t {valid, addr}
  - typedef imem_resp_t {valid, data, err}
  - function addr_ok(addr, depth)
- One natural sub-module, imem_resp_slot, instantiated twice: a one-entry response register with its valid/ready and drain-refill logic.
- Grant logic and the streak counter stay in the top module.

Test Plan:
- **Fetch-only stream:** f_req_valid = 1 with addr 0x0, 0x4, 0x8 back-to-back, f_resp_ready = 1.
  - f_req_ready is high every cycle.
  - Responses equal mem[0], mem[1], mem[2], each one cycle after acceptance, with err = 0.
- **Starvation guard:** both ports continuously valid, MAX_STREAK = 4, responses always drained.
  - Grant pattern is F,F,F,F,D repeating.
  - d_resp_valid rises on cycle 6 after reset release.
- **Error cases:**
  - Debug addr 0x2 → d_resp_err = 1, data = 0.
  - Debug addr 0x1000 with DEPTH = 1024 → err = 1.
  - Next request at addr 0x10 → err = 0, data = mem[4].
- **Backpressure:** f_resp_ready = 0 with a fetch response held.
  - A new fetch request sees f_req_ready = 0, and data stays stable.
  - Debug requests are still granted.
  - Raising f_resp_ready in the same cycle as the new request gives drain and refill in one cycle.
- **Async reset mid-operation:** assert rst_n = 0 between edges while d_resp_valid = 1.
  - All resp_valid drop immediately, and streak = 0.
  - After release, the first grant occurs on the first clock edge with a valid request.
- **With IMEM_ARB_STATS_EN:** run scenario 2 for 10 grants → stat_f_grants = 8, stat_d_grants = 2, stat_err_cnt = 0.
